// File: rtl/prt_vtb_vps_rx.sv
// prt_vtb_vps_rx: VPS stream receiver committing a parameter set after two identical sweeps
// Optional frame-synchronous commit via PRT_VTB_VPS_RX_FSYNC_EN (adds VID_VS_IN).
module prt_vtb_vps_rx #(
  parameter int P_VPS_WORDS = 16,
  parameter int P_IDX_WIDTH = 4,
  parameter int P_DAT_WIDTH = 16
) (
  input  logic                               VID_CLK_IN,
  input  logic                               VID_RST_IN,
  input  logic [P_IDX_WIDTH-1:0]             VPS_IDX_IN,
  input  logic [P_DAT_WIDTH-1:0]             VPS_DAT_IN,
  input  logic                               VPS_VLD_IN,
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
  input  logic                               VID_VS_IN,
`endif
  output logic [P_VPS_WORDS*P_DAT_WIDTH-1:0] VPS_OUT,
  output logic                               LOCK_OUT,
  output logic                               CHG_OUT,
  output logic                               ERR_OUT
);
  localparam int N = P_VPS_WORDS * P_DAT_WIDTH;
  localparam logic [P_IDX_WIDTH-1:0] LAST = P_IDX_WIDTH'(P_VPS_WORDS - 1);
  localparam logic [P_IDX_WIDTH-1:0] ONE  = P_IDX_WIDTH'(1);
  typedef enum logic {HUNT, RUN} state_t;
  state_t                 state_q, state_d;
  logic [P_IDX_WIDTH-1:0] exp_q, exp_d;
  logic [N-1:0]           stage_q, stage_d, cand_q, cand_d, active_q, active_d;
  logic                   done_q, done_d, lock_q, lock_d, chg_q, chg_d, err_q, err_d, seen_q, seen_d;
  logic                   wr;
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
  logic                   pend_q, pend_d, vs_q, vs_p_q;
`endif
  // all state registers, cleared asynchronously
  always_ff @(posedge VID_CLK_IN or negedge VID_RST_IN) begin
    if (!VID_RST_IN) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      stage_q  <= '0;
      cand_q   <= '0;
      active_q <= '0;
      done_q   <= 1'b0;
      lock_q   <= 1'b0;
      chg_q    <= 1'b0;
      err_q    <= 1'b0;
      seen_q   <= 1'b0;
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
      pend_q   <= 1'b0;
      vs_q     <= 1'b0;
      vs_p_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      stage_q  <= stage_d;
      cand_q   <= cand_d;
      active_q <= active_d;
      done_q   <= done_d;
      lock_q   <= lock_d;
      chg_q    <= chg_d;
      err_q    <= err_d;
      seen_q   <= seen_d;
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
      pend_q   <= pend_d;
      vs_q     <= VID_VS_IN;
      vs_p_q   <= vs_q;
`endif
    end
  end
  // sweep tracker: follows expected index, captures words into stage, flags completion and errors
  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    stage_d = stage_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wr      = 1'b0;
    if (VPS_VLD_IN) begin
      if (state_q == HUNT) begin
        if (VPS_IDX_IN == '0) begin
          wr      = 1'b1;
          exp_d   = ONE;
          state_d = RUN;
        end
      end else if (VPS_IDX_IN == exp_q) begin
        wr     = 1'b1;
        done_d = (exp_q == LAST);
        exp_d  = done_d ? '0 : exp_q + ONE;
      end else begin
        err_d = 1'b1;
        if (VPS_IDX_IN == '0) begin
          wr    = 1'b1;
          exp_d = ONE;
        end else begin
          state_d = HUNT;
          exp_d   = '0;
        end
      end
    end
    if (wr) stage_d[int'(VPS_IDX_IN)*P_DAT_WIDTH +: P_DAT_WIDTH] = VPS_DAT_IN;
  end
  // qualification: compare the finished sweep against active and candidate sets
  always_comb begin
    active_d = active_q;
    cand_d   = cand_q;
    lock_d   = lock_q;
    chg_d    = 1'b0;
    seen_d   = seen_q;
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
    pend_d   = pend_q;
`endif
    if (done_q) begin
      if (stage_q == active_q) begin
        if (seen_q) lock_d = 1'b1;
      end else if (stage_q == cand_q) begin
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
        pend_d   = 1'b1;
        lock_d   = 1'b0;
`else
        active_d = stage_q;
        chg_d    = 1'b1;
        lock_d   = 1'b1;
        seen_d   = 1'b1;
`endif
      end else begin
        cand_d = stage_q;
        lock_d = 1'b0;
      end
    end
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
    if (vs_q && !vs_p_q && pend_q) begin
      active_d = cand_q;
      chg_d    = 1'b1;
      pend_d   = 1'b0;
      lock_d   = 1'b1;
      seen_d   = 1'b1;
    end
`endif
    if (err_d) lock_d = 1'b0;
  end
  assign VPS_OUT  = active_q;
  assign LOCK_OUT = lock_q;
  assign CHG_OUT  = chg_q;
  assign ERR_OUT  = err_q;
endmodule

// File: tb/tb_prt_vtb_vps_rx.sv
// tb_prt_vtb_vps_rx: directed self-checking bench for prt_vtb_vps_rx
module tb_prt_vtb_vps_rx;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   idx = '0;
  logic [15:0]  dat = '0;
  logic         vld = 1'b0;
  logic         vs = 1'b0;
  logic [255:0] vps_out;
  logic         lock, chg, err;
  int           checks = 0;
  int           errors = 0;
  prt_vtb_vps_rx dut (
    .VID_CLK_IN (clk),
    .VID_RST_IN (rst_n),
    .VPS_IDX_IN (idx),
    .VPS_DAT_IN (dat),
    .VPS_VLD_IN (vld),
`ifdef PRT_VTB_VPS_RX_FSYNC_EN
    .VID_VS_IN  (vs),
`endif
    .VPS_OUT    (vps_out),
    .LOCK_OUT   (lock),
    .CHG_OUT    (chg),
    .ERR_OUT    (err)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] w(input int k);
    return vps_out[k*16 +: 16];
  endfunction
  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input int k, input logic [15:0] d);
    idx = 4'(k);
    dat = d;
    vld = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    vld = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic sweep(input logic [15:0] base, input logic [15:0] w3);
    for (int k = 0; k < 16; k++) send(k, (k == 3 && w3 != 16'h0) ? w3 : base + 16'(k));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vps", vps_out, '0);
    chk("rst_lock", {255'b0, lock}, 256'd0);
    chk("rst_chg", {255'b0, chg}, 256'd0);
    chk("rst_err", {255'b0, err}, 256'd0);
    rst_n = 1'b1;
    sweep(16'h1000, 16'h0);
    sweep(16'h1000, 16'h0);
    chk("c1_t1_chg", {255'b0, chg}, 256'd0);
    chk("c1_t1_w5", {240'b0, w(5)}, 256'd0);
    idle();
    chk("c1_t2_w5", {240'b0, w(5)}, 256'h1005);
    chk("c1_t2_chg", {255'b0, chg}, 256'd1);
    chk("c1_t2_lock", {255'b0, lock}, 256'd1);
    idle();
    chk("c1_t3_chg", {255'b0, chg}, 256'd0);
    sweep(16'h2000, 16'h0);
    idle();
    chk("s2a_chg", {255'b0, chg}, 256'd0);
    chk("s2a_lock", {255'b0, lock}, 256'd0);
    chk("s2a_w5", {240'b0, w(5)}, 256'h1005);
    sweep(16'h2000, 16'h0);
    idle();
    chk("s2b_chg", {255'b0, chg}, 256'd1);
    chk("s2b_lock", {255'b0, lock}, 256'd1);
    chk("s2b_w5", {240'b0, w(5)}, 256'h2005);
    for (int k = 0; k < 6; k++) send(k, 16'h2000 + 16'(k));
    chk("seq_pre_err", {255'b0, err}, 256'd0);
    send(7, 16'h2007);
    chk("seq_err", {255'b0, err}, 256'd1);
    chk("seq_lock", {255'b0, lock}, 256'd0);
    idle();
    chk("seq_err_end", {255'b0, err}, 256'd0);
    chk("seq_w5", {240'b0, w(5)}, 256'h2005);
    sweep(16'h2000, 16'h0);
    idle();
    chk("resume_lock", {255'b0, lock}, 256'd1);
    chk("resume_chg", {255'b0, chg}, 256'd0);
    sweep(16'h2000, 16'hFFFF);
    idle();
    chk("glitch_chg", {255'b0, chg}, 256'd0);
    chk("glitch_lock", {255'b0, lock}, 256'd0);
    chk("glitch_w3", {240'b0, w(3)}, 256'h2003);
    sweep(16'h2000, 16'h0);
    idle();
    chk("orig_chg", {255'b0, chg}, 256'd0);
    chk("orig_lock", {255'b0, lock}, 256'd1);
    chk("orig_w3", {240'b0, w(3)}, 256'h2003);
    for (int k = 0; k < 8; k++) send(k, 16'h3000 + 16'(k));
    idx = 4'd8;
    dat = 16'h3008;
    vld = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vps", vps_out, '0);
    chk("mrst_lock", {255'b0, lock}, 256'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 9; k < 16; k++) begin
      send(k, 16'h3000 + 16'(k));
      chk($sformatf("hunt_err_%0d", k), {255'b0, err}, 256'd0);
    end
    sweep(16'h3000, 16'h0);
    idle();
    chk("fresh1_chg", {255'b0, chg}, 256'd0);
    chk("fresh1_vps", vps_out, '0);
    sweep(16'h3000, 16'h0);
    idle();
    chk("fresh2_chg", {255'b0, chg}, 256'd1);
    chk("fresh2_w5", {240'b0, w(5)}, 256'h3005);
    chk("fresh2_lock", {255'b0, lock}, 256'd1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
